msf_strobe_gen: RTL and testbench
=================================

# msf_strobe_gen

Timing strobe generator for the MSF receive chain. From the system clock it derives the sample strobe, the 60 kHz carrier-period pulse and the one-second marker that drive the IQ averager (`load_val`, `msf_carrier_pulse`, `one_sec_marker`). An optional PPS reference can re-align the second boundary, with lock tracking.

## Interface
- `PHASE_BITS`, 32: width of the carrier phase accumulator.
- `PHASE_INC`, 2577: per-clock phase increment; carrier rate = f_clk·PHASE_INC/2^PHASE_BITS (60 kHz at 100 MHz).
- `SAMPLE_DIV`, 16: clocks per `load_val` strobe; legal range ≥ 2.
- `CARRIERS_PER_SEC`, 60000: carrier pulses per second; legal range ≥ 2.
- `LOCK_TOL`, 8: PPS acceptance window, in carrier periods either side of the wrap.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `enable` in 1: run/hold.
- `pps_in` in 1: asynchronous 1 PPS reference, rising edge significant.
- `load_val` out 1: one-cycle sample strobe.
- `msf_carrier_pulse` out 1: one-cycle pulse per carrier period.
- `one_sec_marker` out 1: one-cycle pulse per second.
- `carrier_idx` out 16: carrier periods elapsed in the current second.
- `locked` out 1: PPS lock status.

## Operation
- All outputs are registered. Reset values are 0 for all outputs, for the phase accumulator and the sample counter, and for the 2-flop PPS synchroniser. The lock FSM resets to SEARCH.
- `enable`=0: all internal counters hold and all strobes are 0. `carrier_idx` and `locked` hold. On re-enable, counting resumes from the held values.
- Sample counter:
  - Counts 0..SAMPLE_DIV-1.
  - `load_val`=1 in the cycle after the counter equals SAMPLE_DIV-1.
- Carrier NCO:
  - Each enabled cycle: phase ← phase + PHASE_INC, modulo 2^PHASE_BITS.
  - The carry-out is registered as `msf_carrier_pulse`.
- Second counter:
  - `carrier_idx` increments on each carrier pulse.
  - When it is at CARRIERS_PER_SEC-1, the next pulse wraps it to 0 and asserts `one_sec_marker` in the same cycle as that pulse.
- PPS path (macro enabled):
  - `pps_in` passes through the 2-flop synchroniser, then a registered rising-edge detect.
  - On a detected edge: phase, the sample counter and `carrier_idx` clear to 0.
  - `one_sec_marker` and `msf_carrier_pulse` assert in the following cycle.
  - A free-running wrap in that same cycle yields a single marker, never two.
- Lock FSM:
  - SEARCH (`locked`=0): a PPS edge with `carrier_idx` ≥ CARRIERS_PER_SEC-LOCK_TOL or ≤ LOCK_TOL → LOCKED. Any other PPS edge only realigns.
  - LOCKED (`locked`=1): an in-window edge stays LOCKED. An out-of-window edge → SEARCH. A free-running wrap with no PPS edge since the last marker → HOLDOVER.
  - HOLDOVER (`locked`=1): an in-window edge → LOCKED. An out-of-window edge, or a second missed wrap → SEARCH.
- Width rules:
  - `carrier_idx` is 16 bits; CARRIERS_PER_SEC must be ≤ 65536.
  - The sample counter is sized to $clog2(SAMPLE_DIV).

## Timing
- Latency from pps_in going high (first sampling edge) to `one_sec_marker` is 4 clocks (2 sync + 1 edge detect + 1 output register).
- First `load_val` after reset release with `enable`=1: cycle SAMPLE_DIV+1.
- First carrier pulse: the cycle after accumulated phase first reaches 2^PHASE_BITS.
- Spacing between consecutive markers (free-run): exactly CARRIERS_PER_SEC carrier pulses.
- Reset mid-operation: all outputs are 0 in the cycle after `rst` is sampled high, and the FSM is in SEARCH.
- `rst` overrides `enable` and PPS.

## Configuration
- `MSF_PPS_SYNC_EN` defined:
  - PPS synchroniser, edge detect, realignment and the lock FSM are built.
- `MSF_PPS_SYNC_EN` undefined:
  - `pps_in` is ignored and no synchroniser flops are built.
  - `locked` is tied to 0.
  - Markers come only from the free-running wrap.

## Test plan
All scenarios use PHASE_BITS=32, PHASE_INC=2^30, SAMPLE_DIV=3, CARRIERS_PER_SEC=10, LOCK_TOL=1.
- Free run, enable=1 after reset -> `load_val` in every 3rd cycle starting at cycle 4. Carrier pulse every 4 cycles. `one_sec_marker` with every 10th pulse, coincident with `carrier_idx`=0.
- enable=0 for 7 cycles mid-second -> no strobes; `carrier_idx` frozen. On re-enable, pulse spacing continues from the held phase.
- PPS edge while `carrier_idx`=9 (in window) -> marker 4 cycles after pps_in rises; only one marker even if the free-run wrap coincides; `locked`=1.
- While LOCKED, withhold PPS for 2 seconds -> `locked` stays 1 after the first missed wrap (HOLDOVER) and drops to 0 at the second.
- PPS edge at `carrier_idx`=5 while LOCKED -> realign to 0 and `locked`=0. Build without `MSF_PPS_SYNC_EN` -> PPS edges have no effect and `locked` is constantly 0.

Source files
------------

// File: rtl/msf_strobe_gen.sv
`timescale 1ns/1ps
// MSF timing strobe generator: sample strobe, 60 kHz carrier pulse, one-second marker.
// Define MSF_PPS_SYNC_EN to build the PPS realignment path and lock tracking.
module msf_strobe_gen #(
    parameter int          PHASE_BITS       = 32,
    parameter int unsigned PHASE_INC        = 2577,
    parameter int          SAMPLE_DIV       = 16,
    parameter int          CARRIERS_PER_SEC = 60000,
    parameter int          LOCK_TOL         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pps_in,
    output logic        load_val,
    output logic        msf_carrier_pulse,
    output logic        one_sec_marker,
    output logic [15:0] carrier_idx,
    output logic        locked
);

    localparam int            SW        = $clog2(SAMPLE_DIV);
    localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [15:0]   IDX_LAST  = 16'(CARRIERS_PER_SEC - 1);

    logic [PHASE_BITS-1:0] phase;
    logic [PHASE_BITS:0]   phase_sum;
    logic [SW-1:0]         samp_cnt;
    logic                  carry;
    logic                  wrap;
    logic                  pps_edge;

    assign phase_sum = {1'b0, phase} + (PHASE_BITS+1)'(PHASE_INC);
    assign carry     = phase_sum[PHASE_BITS];
    assign wrap      = carry && (carrier_idx == IDX_LAST);

    // A PPS realignment takes priority, so a coincident free-run wrap cannot add a second marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase             <= '0;
            samp_cnt          <= '0;
            carrier_idx       <= '0;
            load_val          <= 1'b0;
            msf_carrier_pulse <= 1'b0;
            one_sec_marker    <= 1'b0;
        end else if (!enable) begin
            load_val          <= 1'b0;
            msf_carrier_pulse <= 1'b0;
            one_sec_marker    <= 1'b0;
        end else if (pps_edge) begin
            phase             <= '0;
            samp_cnt          <= '0;
            carrier_idx       <= '0;
            load_val          <= 1'b0;
            msf_carrier_pulse <= 1'b1;
            one_sec_marker    <= 1'b1;
        end else begin
            // NOTE: every register here uses <= so all updates see the pre-edge values.
            phase             <= phase_sum[PHASE_BITS-1:0];
            samp_cnt          <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + SW'(1);
            load_val          <= (samp_cnt == SAMP_LAST);
            msf_carrier_pulse <= carry;
            one_sec_marker    <= wrap;
            if (carry) begin
                carrier_idx <= wrap ? 16'd0 : carrier_idx + 16'd1;
            end
        end
    end

`ifdef MSF_PPS_SYNC_EN

    localparam logic [16:0] WIN_LO = 17'(LOCK_TOL);
    localparam logic [16:0] WIN_HI = 17'(CARRIERS_PER_SEC - LOCK_TOL);

    localparam logic [1:0] S_SEARCH   = 2'd0;
    localparam logic [1:0] S_LOCKED   = 2'd1;
    localparam logic [1:0] S_HOLDOVER = 2'd2;

    logic [1:0] pps_sync;
    logic       pps_prev;
    logic [1:0] state;
    logic [1:0] state_next;
    logic       in_window;

    always_ff @(posedge clk) begin
        if (rst) begin
            pps_sync <= 2'b00;
            pps_prev <= 1'b0;
            pps_edge <= 1'b0;
        end else begin
            pps_sync <= {pps_sync[0], pps_in};
            pps_prev <= pps_sync[1];
            pps_edge <= pps_sync[1] & ~pps_prev;
        end
    end

    assign in_window = ({1'b0, carrier_idx} >= WIN_HI) || ({1'b0, carrier_idx} <= WIN_LO);

    // Every PPS edge makes its own marker, so a free-run wrap is always a missed second.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        state_next = state;
        if (pps_edge) begin
            state_next = in_window ? S_LOCKED : S_SEARCH;
        end else if (wrap) begin
            case (state)
                S_LOCKED:   state_next = S_HOLDOVER;
                S_HOLDOVER: state_next = S_SEARCH;
                default:    state_next = S_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_SEARCH;
            locked <= 1'b0;
        end else if (enable) begin
            state  <= state_next;
            locked <= (state_next != S_SEARCH);
        end
    end

`else

    // Without the PPS path the reference input and tolerance have no effect.
    logic pps_unused;
    assign pps_unused = pps_in ^ (LOCK_TOL != 0);
    assign pps_edge   = 1'b0;
    assign locked     = 1'b0;

`endif

endmodule

// File: tb/tb_msf_strobe_gen.sv
`timescale 1ns/1ps
// Self-checking bench for msf_strobe_gen: vector table, corner sequences and a
// randomized run against a count-based reference model.
module tb_msf_strobe_gen;

    localparam int     PB  = 32;
    localparam longint INC = 64'h4000_0000;
    localparam int     SD  = 3;
    localparam int     CPS = 10;
    localparam int     TOL = 1;
`ifdef MSF_PPS_SYNC_EN
    localparam bit PPS_BUILT = 1'b1;
`else
    localparam bit PPS_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pps_in;
    logic        load_val;
    logic        msf_carrier_pulse;
    logic        one_sec_marker;
    logic [15:0] carrier_idx;
    logic        locked;

    msf_strobe_gen #(
        .PHASE_BITS      (PB),
        .PHASE_INC       (32'h4000_0000),
        .SAMPLE_DIV      (SD),
        .CARRIERS_PER_SEC(CPS),
        .LOCK_TOL        (TOL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .pps_in           (pps_in),
        .load_val         (load_val),
        .msf_carrier_pulse(msf_carrier_pulse),
        .one_sec_marker   (one_sec_marker),
        .carrier_idx      (carrier_idx),
        .locked           (locked)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: counts enabled cycles since the last alignment; pulses and the
    // second index follow from integer division of the accumulated phase.
    typedef enum {M_SEARCH, M_LOCKED, M_HOLD} mlock_t;
    longint      m_n = 0;
    logic [4:0]  m_hist = '0;
    mlock_t      m_lock = M_SEARCH;
    logic        m_load = 1'b0, m_pulse = 1'b0, m_marker = 1'b0, m_locked = 1'b0;
    logic [15:0] m_idx = '0;

    function automatic longint pulses_at(input longint n);
        return (n * INC) >> PB;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic p);
        longint old_p;
        longint new_p;
        bit     pps_hit;
        bit     in_win;
        if (r) begin
            m_n = 0; m_hist = '0; m_lock = M_SEARCH;
            m_load = 1'b0; m_pulse = 1'b0; m_marker = 1'b0; m_idx = '0;
        end else begin
            m_hist  = {m_hist[3:0], p};
            pps_hit = PPS_BUILT && m_hist[3] && !m_hist[4];
            if (!e) begin
                m_load = 1'b0; m_pulse = 1'b0; m_marker = 1'b0;
            end else if (pps_hit) begin
                in_win = (int'(m_idx) >= CPS - TOL) || (int'(m_idx) <= TOL);
                m_lock = in_win ? M_LOCKED : M_SEARCH;
                m_n = 0; m_load = 1'b0; m_pulse = 1'b1; m_marker = 1'b1; m_idx = '0;
            end else begin
                m_load   = (m_n % SD) == SD - 1;
                old_p    = pulses_at(m_n);
                m_n      = m_n + 1;
                new_p    = pulses_at(m_n);
                m_pulse  = new_p != old_p;
                m_idx    = 16'(new_p % CPS);
                m_marker = m_pulse && (m_idx == 16'd0);
                if (m_marker) begin
                    case (m_lock)
                        M_LOCKED: m_lock = M_HOLD;
                        default:  m_lock = M_SEARCH;
                    endcase
                end
            end
        end
        m_locked = PPS_BUILT && (m_lock != M_SEARCH);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(rst, enable, pps_in);
        #1;
    endtask

    task automatic check_model(input string name);
        check(name, 32'({load_val, msf_carrier_pulse, one_sec_marker, locked, carrier_idx}),
              32'({m_load, m_pulse, m_marker, m_locked, m_idx}));
    endtask

    task automatic wait_idx(input int idx, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            check_model(name);
            if (msf_carrier_pulse && carrier_idx == 16'(idx)) found = 1'b1;
        end
        check({name, "_reached"}, 32'(found), 32'd1);
    endtask

    task automatic wait_marker(input string name, output int pulses);
        bit found = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            check_model(name);
            if (msf_carrier_pulse) pulses++;
            if (one_sec_marker) found = 1'b1;
        end
        check({name, "_reached"}, 32'(found), 32'd1);
    endtask

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        pps;
        logic        load;
        logic        pulse;
        logic        marker;
        logic        lck;
        logic [15:0] idx;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] in_bits, input logic [3:0] out_bits, input int idx);
        return {in_bits, out_bits, 16'(idx)};
    endfunction

    vec_t vecs [19];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int en_edges;
        int first_k;
        int n_mark;

        // inputs {rst,en,pps}, outputs {load,pulse,marker,locked}, carrier_idx
        vecs[0]  = mk(3'b110, 4'b0000, 0);
        vecs[1]  = mk(3'b010, 4'b0000, 0);
        vecs[2]  = mk(3'b010, 4'b0000, 0);
        vecs[3]  = mk(3'b010, 4'b1000, 0);
        vecs[4]  = mk(3'b010, 4'b0100, 1);
        vecs[5]  = mk(3'b010, 4'b0000, 1);
        vecs[6]  = mk(3'b010, 4'b1000, 1);
        vecs[7]  = mk(3'b010, 4'b0000, 1);
        vecs[8]  = mk(3'b010, 4'b0100, 2);
        vecs[9]  = mk(3'b010, 4'b1000, 2);
        vecs[10] = mk(3'b010, 4'b0000, 2);
        vecs[11] = mk(3'b010, 4'b0000, 2);
        vecs[12] = mk(3'b010, 4'b1100, 3);
        vecs[13] = mk(3'b000, 4'b0000, 3);
        vecs[14] = mk(3'b000, 4'b0000, 3);
        vecs[15] = mk(3'b010, 4'b0000, 3);
        vecs[16] = mk(3'b010, 4'b0000, 3);
        vecs[17] = mk(3'b010, 4'b1000, 3);
        vecs[18] = mk(3'b010, 4'b0100, 4);

        rst = 1'b1; enable = 1'b0; pps_in = 1'b0;
        cycle();
        cycle();

        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; enable = vecs[i].en; pps_in = vecs[i].pps;
            cycle();
            check($sformatf("vec%0d", i),
                  32'({load_val, msf_carrier_pulse, one_sec_marker, locked, carrier_idx}),
                  32'({vecs[i].load, vecs[i].pulse, vecs[i].marker, vecs[i].lck, vecs[i].idx}));
        end

        // Hold for 7 cycles mid-second, then the phase resumes where it stopped.
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("hold_strobes", 32'({load_val, msf_carrier_pulse, one_sec_marker}), 32'd0);
            check("hold_idx", 32'(carrier_idx), 32'd4);
        end
        enable = 1'b1;
        en_edges = 0;
        for (int i = 0; i < 20 && !msf_carrier_pulse; i++) begin
            cycle();
            check_model("resume");
            en_edges++;
        end
        check("resume_spacing", 32'(en_edges), 32'd4);
        check("resume_idx", 32'(carrier_idx), 32'd5);

        // Free-run marker spacing.
        wait_marker("marker1", p);
        check("marker_idx", 32'(carrier_idx), 32'd0);
        wait_marker("marker2", p);
        check("marker_spacing", 32'(p), 32'd10);

`ifdef MSF_PPS_SYNC_EN
        // In-window PPS coinciding with the free-run wrap.
        wait_idx(9, "pps9");
        pps_in = 1'b1;
        first_k = 0; n_mark = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check_model("pps9_run");
            if (one_sec_marker) begin
                n_mark++;
                if (first_k == 0) first_k = k;
            end
        end
        check("pps_latency", 32'(first_k), 32'd4);
        check("pps_single_marker", 32'(n_mark), 32'd1);
        check("pps_locked", 32'(locked), 32'd1);
        pps_in = 1'b0;

        // Two missed seconds: holdover, then loss of lock.
        wait_marker("miss1", p);
        check("holdover_locked", 32'(locked), 32'd1);
        wait_marker("miss2", p);
        check("holdover_drop", 32'(locked), 32'd0);

        // Relock, then an out-of-window edge.
        wait_idx(9, "relock");
        pps_in = 1'b1;
        for (int k = 0; k < 4; k++) begin cycle(); check_model("relock_run"); end
        check("relock_locked", 32'(locked), 32'd1);
        pps_in = 1'b0;
        wait_idx(5, "late5");
        pps_in = 1'b1;
        for (int k = 0; k < 4; k++) begin cycle(); check_model("late_run"); end
        check("late_realign", 32'({one_sec_marker, carrier_idx}), 32'h1_0000);
        check("late_unlocked", 32'(locked), 32'd0);
        pps_in = 1'b0;
`else
        // PPS edges are ignored in this build.
        wait_idx(5, "nopps5");
        pps_in = 1'b1;
        for (int k = 0; k < 4; k++) begin cycle(); check_model("nopps_run"); end
        check("nopps_no_realign", 32'({one_sec_marker, carrier_idx}), 32'd6);
        check("nopps_unlocked", 32'(locked), 32'd0);
        pps_in = 1'b0;
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 499) == 0);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 59) == 0) pps_in = ~pps_in;
            cycle();
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
